// File: rtl/rv32_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: datapath width, instruction size,
// default fetch vectors and the sequencer state encoding.
package rv32_fetch_ctrl_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned INSN_BYTES = 4;

   localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEF_TRAP_VEC = 32'h0000_0004;

   typedef enum logic [1:0] {
      S_RST     = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_e;

   // Redirect targets must be word aligned; anything else traps.
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/rv32_fetch_skid.sv
// One-entry {pc,instr} holding buffer used when the output register is
// stalled while imem delivers a word. Clear has priority over push/pop.
module rv32_fetch_skid
   import rv32_fetch_ctrl_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic            i_clear,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_instr,
   output logic            o_full,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_instr
);

   logic            r_full;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;

   // Entry storage and occupancy flag.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_full  <= 1'b0;
         r_pc    <= '0;
         r_instr <= '0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (i_push) begin
         r_full  <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

   assign o_full  = r_full;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/rv32_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the imem request handshake,
// buffers delivered words against ID stalls and redirects on taken
// control flow from EX, flushing the younger stages.
module rv32_fetch_ctrl
   import rv32_fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [XLEN-1:0] TRAP_VEC = DEF_TRAP_VEC
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            stall_in,
   input  logic            br_valid_in,
   input  logic            br_taken_in,
   input  logic [XLEN-1:0] br_target_in,
   output logic            imem_req_out,
   output logic [XLEN-1:0] imem_addr_out,
   input  logic            imem_ack_in,
   input  logic [XLEN-1:0] imem_data_in,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out,
   output logic            instr_valid_out,
   output logic            flush_out,
   output logic            misaligned_out
);

   fetch_state_e    r_state, w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_disc_pc;
   logic [XLEN-1:0] r_instr, r_pc;
   logic            r_valid, r_flush, r_misal;

   logic            w_redirect, w_misal, w_req, w_ack, w_accept, w_held;
   logic            w_skid_full, w_push, w_pop;
   logic [XLEN-1:0] w_addr, w_target, w_skid_pc, w_skid_instr;

   assign w_redirect = br_valid_in & br_taken_in;
   assign w_misal    = is_misaligned(br_target_in[1:0]);
   assign w_target   = w_misal ? TRAP_VEC : br_target_in;

   // Next state and request/address generation.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_addr      = '0;
      case (r_state)
         S_RST: w_state_nxt = S_FETCH;
         S_FETCH: begin
            w_req = ~w_skid_full;
            if (w_req) w_addr = r_fetch_pc;
            if (w_redirect && w_req && !imem_ack_in) w_state_nxt = S_DISCARD;
         end
         S_DISCARD: begin
            // The pre-redirect request must complete before the target is fetched.
            w_req  = 1'b1;
            w_addr = r_disc_pc;
            if (imem_ack_in) w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_RST;
      endcase
   end

   assign w_ack    = imem_ack_in & w_req;
   assign w_accept = (r_state == S_FETCH) & w_ack & ~w_redirect;
   // An empty output register is loaded even during a stall.
   assign w_held   = r_valid & stall_in;
   assign w_push   = w_accept & w_held;
   assign w_pop    = ~w_held & w_skid_full & ~w_redirect;

   rv32_fetch_skid u_skid (
      .i_clk   (clk_in),
      .i_rst_n (rst_in),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_redirect),
      .i_pc    (r_fetch_pc),
      .i_instr (imem_data_in),
      .o_full  (w_skid_full),
      .o_pc    (w_skid_pc),
      .o_instr (w_skid_instr)
   );

   // State register, fetch PC, discard address and redirect pulses.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state    <= S_RST;
         r_fetch_pc <= RESET_PC;
         r_disc_pc  <= '0;
         r_flush    <= 1'b0;
         r_misal    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_flush <= w_redirect;
         r_misal <= w_redirect & w_misal;
         if (w_redirect)    r_fetch_pc <= w_target;
         else if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(INSN_BYTES);
         if (r_state == S_FETCH && w_state_nxt == S_DISCARD) r_disc_pc <= r_fetch_pc;
      end
   end

   // Output register: hold on stall, drain skid first, otherwise take the new word.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= '0;
      end else if (w_redirect) begin
         r_valid <= 1'b0;
      end else if (!w_held) begin
         if (w_skid_full) begin
            r_valid <= 1'b1;
            r_pc    <= w_skid_pc;
            r_instr <= w_skid_instr;
         end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= r_fetch_pc;
            r_instr <= imem_data_in;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign imem_req_out    = w_req;
   assign imem_addr_out   = w_addr;
   assign instr_out       = r_instr;
   assign pc_out          = r_pc;
   assign instr_valid_out = r_valid;
   assign flush_out       = r_flush;
   assign misaligned_out  = r_misal;

endmodule

// File: tb/tb_rv32_fetch_ctrl.sv
// Bench for rv32_fetch_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model that keeps the
// delivered-but-unconsumed instructions as a queue of at most two entries.
module tb_rv32_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0004;

   logic        clk_in = 1'b0;
   logic        rst_in, stall_in, br_valid_in, br_taken_in, imem_ack_in;
   logic [31:0] br_target_in, imem_data_in;
   logic        imem_req_out, instr_valid_out, flush_out, misaligned_out;
   logic [31:0] imem_addr_out, instr_out, pc_out;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   // Model state
   ent_t        m_q[$];
   bit          m_rst   = 1'b1;
   bit          m_disc  = 1'b0;
   bit          m_flush = 1'b0;
   bit          m_mis   = 1'b0;
   logic [31:0] m_pc    = RESET_PC;
   logic [31:0] m_disc_addr = '0;

   rv32_fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .stall_in        (stall_in),
      .br_valid_in     (br_valid_in),
      .br_taken_in     (br_taken_in),
      .br_target_in    (br_target_in),
      .imem_req_out    (imem_req_out),
      .imem_addr_out   (imem_addr_out),
      .imem_ack_in     (imem_ack_in),
      .imem_data_in    (imem_data_in),
      .instr_out       (instr_out),
      .pc_out          (pc_out),
      .instr_valid_out (instr_valid_out),
      .flush_out       (flush_out),
      .misaligned_out  (misaligned_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic exp_req();
      return !m_rst && (m_disc || m_q.size() < 2);
   endfunction

   function automatic logic [31:0] exp_addr();
      if (!exp_req()) return 32'h0;
      return m_disc ? m_disc_addr : m_pc;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("req",   32'(imem_req_out),    32'(exp_req()));
      chk("addr",  imem_addr_out,        exp_addr());
      chk("valid", 32'(instr_valid_out), 32'(m_q.size() > 0));
      chk("flush", 32'(flush_out),       32'(m_flush));
      chk("misal", 32'(misaligned_out),  32'(m_mis));
      if (m_q.size() > 0) begin
         chk("pc_out",    pc_out,    m_q[0].pc);
         chk("instr_out", instr_out, m_q[0].ins);
      end
   endtask

   task automatic model_edge(input logic rst, input logic stall, input logic brv,
                             input logic brt, input logic [31:0] tgt,
                             input logic ack, input logic [31:0] data);
      logic        redir, req_now, mis;
      logic [31:0] dest;
      ent_t        e;
      if (!rst) begin
         m_rst = 1'b1; m_disc = 1'b0; m_pc = RESET_PC;
         m_q.delete(); m_flush = 1'b0; m_mis = 1'b0;
         return;
      end
      redir   = brv & brt;
      mis     = (tgt[1:0] != 2'b00);
      dest    = mis ? TRAP_VEC : tgt;
      req_now = exp_req();
      m_flush = redir;
      m_mis   = redir & mis;
      if (m_rst) begin
         m_rst = 1'b0;
         if (redir) m_pc = dest;
      end else if (redir) begin
         m_q.delete();
         if (m_disc) m_disc = !ack;
         else if (req_now && !ack) begin
            m_disc = 1'b1;
            m_disc_addr = m_pc;
         end
         m_pc = dest;
      end else if (m_disc) begin
         if (ack) m_disc = 1'b0;
      end else begin
         if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
         if (ack) begin
            e.pc = m_pc; e.ins = data;
            m_q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // One clock cycle: drive, check mid-cycle, advance model at the edge.
   task automatic step(input logic rst, input logic stall, input logic brv,
                       input logic brt, input logic [31:0] tgt, input logic ack);
      logic        a;
      logic [31:0] d;
      a = ack & exp_req();
      d = $urandom;
      rst_in = rst; stall_in = stall; br_valid_in = brv; br_taken_in = brt;
      br_target_in = tgt; imem_ack_in = a; imem_data_in = d;
      @(negedge clk_in);
      check_outputs();
      @(posedge clk_in);
      model_edge(rst, stall, brv, brt, tgt, a, d);
      #1;
   endtask

   initial begin
      logic        r, s, v, t, k;
      logic [31:0] tg;
      // reset held
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      // 1: ack every cycle, no stall
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      // 2: stall three cycles with acks arriving, then release
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      // 3: redirect to 0x100 with the outstanding ack delayed two cycles
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      // 4: redirect coinciding with ack and stall
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      // not-taken and taken-without-valid are ignored
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
      // 5: misaligned target
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      // back-to-back redirects
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      // 6: reset mid-request, then PC wrap at the top of the address space
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(99) != 0);
         s  = ($urandom_range(9) < 3);
         v  = ($urandom_range(9) == 0);
         t  = ($urandom_range(9) < 7);
         k  = ($urandom_range(9) < 6);
         case ($urandom_range(3))
            0:       tg = $urandom;
            1:       tg = 32'hFFFF_FFFC;
            default: tg = $urandom & 32'hFFFF_FFFC;
         endcase
         step(r, s, v, t, tg, k);
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
